// File: rtl/ixu_mc_sched.sv
// Age-ordered issue scheduler for the IXU multi-cycle pipe with divide-occupancy stall FSM.
// Optional stall counter output enabled by defining IXU_MC_SCHED_STALL_CNT_EN.
module ixu_mc_sched #(
  parameter int unsigned DEPTH = 8,
  parameter int unsigned TAG_W = 6
) (
  input  logic                         core_clock_i,
  input  logic                         core_reset_ni,
  input  logic                         core_flush_i,
  input  logic                         enq_valid_i,
  input  logic [17:0]                  enq_data_i,
  input  logic                         enq_div_i,
  input  logic                         enq_rs1_rdy_i,
  input  logic                         enq_rs2_rdy_i,
  output logic                         enq_ready_o,
  input  logic                         wk0_valid_i,
  input  logic [TAG_W-1:0]             wk0_dest_i,
  input  logic                         wk1_valid_i,
  input  logic [TAG_W-1:0]             wk1_dest_i,
  input  logic                         div_done_i,
  output logic                         issue_valid_o,
  output logic [17:0]                  issue_data_o,
  output logic [$clog2(DEPTH+1)-1:0]   occupancy_o
`ifdef IXU_MC_SCHED_STALL_CNT_EN
  ,
  output logic [31:0]                  stall_cnt_o
`endif
);

  localparam int unsigned CNT_W = $clog2(DEPTH + 1);
  localparam int unsigned IDX_W = $clog2(DEPTH);

  typedef struct packed {
    logic [17:0] data;
    logic        div;
    logic        rs1_rdy;
    logic        rs2_rdy;
  } entry_t;

  typedef enum logic {
    S_RUN,
    S_WAIT_DIV
  } state_t;

  entry_t             ent_q [DEPTH];
  entry_t             ent_d [DEPTH];
  entry_t             woke  [DEPTH];
  entry_t             new_ent;
  logic [CNT_W-1:0]   count_q;
  logic [CNT_W-1:0]   count_d;
  logic [CNT_W-1:0]   enq_idx;
  logic [IDX_W-1:0]   sel;
  logic               found;
  logic               issue;
  logic               enq_acc;
  state_t             state_q;
  state_t             state_d;

  function automatic logic wake_hit(input logic [5:0]       tag,
                                    input logic             v0,
                                    input logic [TAG_W-1:0] d0,
                                    input logic             v1,
                                    input logic [TAG_W-1:0] d1);
    return (v0 && (d0 == TAG_W'(tag))) || (v1 && (d1 == TAG_W'(tag)));
  endfunction

  // Oldest-first select over the registered (pre-wakeup) ready bits.
  always_comb begin
    found = 1'b0;
    sel   = '0;
    for (int unsigned i = 0; i < DEPTH; i++) begin
      if (!found && (i < 32'(count_q)) && ent_q[i].rs1_rdy && ent_q[i].rs2_rdy) begin
        found = 1'b1;
        sel   = IDX_W'(i);
      end
    end
  end

  assign enq_ready_o   = (count_q < CNT_W'(DEPTH));
  assign occupancy_o   = count_q;
  assign issue         = (state_q == S_RUN) && found && !core_flush_i;
  assign enq_acc       = enq_valid_i && enq_ready_o && !core_flush_i;
  assign issue_valid_o = issue;
  assign issue_data_o  = issue ? ent_q[sel].data : '0;

  always_comb begin
    new_ent.data    = enq_data_i;
    new_ent.div     = enq_div_i;
    new_ent.rs1_rdy = enq_rs1_rdy_i || (enq_data_i[11:6] == 6'd0) ||
                      wake_hit(enq_data_i[11:6], wk0_valid_i, wk0_dest_i, wk1_valid_i, wk1_dest_i);
    new_ent.rs2_rdy = enq_rs2_rdy_i || (enq_data_i[17:12] == 6'd0) ||
                      wake_hit(enq_data_i[17:12], wk0_valid_i, wk0_dest_i, wk1_valid_i, wk1_dest_i);
  end

  // Wakeup is applied before the collapse so a shifting entry keeps its newly set bits.
  always_comb begin
    for (int unsigned i = 0; i < DEPTH; i++) begin
      woke[i] = ent_q[i];
      if (wake_hit(ent_q[i].data[11:6], wk0_valid_i, wk0_dest_i, wk1_valid_i, wk1_dest_i))
        woke[i].rs1_rdy = 1'b1;
      if (wake_hit(ent_q[i].data[17:12], wk0_valid_i, wk0_dest_i, wk1_valid_i, wk1_dest_i))
        woke[i].rs2_rdy = 1'b1;
    end
    ent_d = woke;
    if (issue) begin
      for (int unsigned i = 0; i < DEPTH - 1; i++) begin
        if (i >= 32'(sel))
          ent_d[i] = woke[i+1];
      end
    end
    enq_idx = issue ? (count_q - CNT_W'(1)) : count_q;
    if (enq_acc)
      ent_d[IDX_W'(enq_idx)] = new_ent;
  end

  always_comb begin
    if (core_flush_i)
      count_d = '0;
    else
      count_d = count_q + CNT_W'(enq_acc) - CNT_W'(issue);
  end

  always_comb begin
    state_d = state_q;
    if (core_flush_i) begin
      state_d = S_RUN;
    end else begin
      case (state_q)
        S_RUN:      if (issue && ent_q[sel].div) state_d = S_WAIT_DIV;
        S_WAIT_DIV: if (div_done_i) state_d = S_RUN;
        default:    state_d = S_RUN;
      endcase
    end
  end

  always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
    if (!core_reset_ni) begin
      count_q <= '0;
      state_q <= S_RUN;
      for (int unsigned i = 0; i < DEPTH; i++)
        ent_q[i] <= '0;
    end else begin
      count_q <= count_d;
      state_q <= state_d;
      for (int unsigned i = 0; i < DEPTH; i++)
        ent_q[i] <= ent_d[i];
    end
  end

`ifdef IXU_MC_SCHED_STALL_CNT_EN
  always_ff @(posedge core_clock_i or negedge core_reset_ni) begin
    if (!core_reset_ni)
      stall_cnt_o <= '0;
    else if (found && (state_q == S_WAIT_DIV) && (stall_cnt_o != '1))
      stall_cnt_o <= stall_cnt_o + 32'd1;
  end
`endif

endmodule

// File: tb/tb_ixu_mc_sched.sv
// Directed self-checking bench for ixu_mc_sched (DEPTH=8, TAG_W=6).
module tb_ixu_mc_sched;

  logic        clk;
  logic        rst_n;
  logic        flush;
  logic        enq_valid;
  logic [17:0] enq_data;
  logic        enq_div;
  logic        enq_rs1_rdy;
  logic        enq_rs2_rdy;
  logic        enq_ready;
  logic        wk0_valid;
  logic [5:0]  wk0_dest;
  logic        wk1_valid;
  logic [5:0]  wk1_dest;
  logic        div_done;
  logic        issue_valid;
  logic [17:0] issue_data;
  logic [3:0]  occupancy;
`ifdef IXU_MC_SCHED_STALL_CNT_EN
  logic [31:0] stall_cnt;
`endif

  int total = 0;
  int bad   = 0;

  ixu_mc_sched #(.DEPTH(8), .TAG_W(6)) dut (
    .core_clock_i  (clk),
    .core_reset_ni (rst_n),
    .core_flush_i  (flush),
    .enq_valid_i   (enq_valid),
    .enq_data_i    (enq_data),
    .enq_div_i     (enq_div),
    .enq_rs1_rdy_i (enq_rs1_rdy),
    .enq_rs2_rdy_i (enq_rs2_rdy),
    .enq_ready_o   (enq_ready),
    .wk0_valid_i   (wk0_valid),
    .wk0_dest_i    (wk0_dest),
    .wk1_valid_i   (wk1_valid),
    .wk1_dest_i    (wk1_dest),
    .div_done_i    (div_done),
    .issue_valid_o (issue_valid),
    .issue_data_o  (issue_data),
    .occupancy_o   (occupancy)
`ifdef IXU_MC_SCHED_STALL_CNT_EN
    ,
    .stall_cnt_o   (stall_cnt)
`endif
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [17:0] pk(input int rs2, input int rs1, input int rob);
    return {6'(rs2), 6'(rs1), 6'(rob)};
  endfunction

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) else begin
      bad++;
      $error("FAIL %s observed=%0d expected=%0d", tag, obs, exp);
    end
  endtask

  task automatic clr();
    flush = 0; enq_valid = 0; enq_data = '0; enq_div = 0;
    enq_rs1_rdy = 0; enq_rs2_rdy = 0;
    wk0_valid = 0; wk0_dest = '0; wk1_valid = 0; wk1_dest = '0; div_done = 0;
  endtask

  task automatic enq(input logic [17:0] d, input logic dv, input logic r1, input logic r2);
    enq_valid = 1; enq_data = d; enq_div = dv; enq_rs1_rdy = r1; enq_rs2_rdy = r2;
  endtask

  // Advance one cycle; inputs are re-driven 1ns after the edge and outputs checked 1ns later.
  task automatic tick();
    @(posedge clk);
    #1;
    clr();
  endtask

  initial begin
    clr();
    rst_n = 0;
    #2;
    chk("rst_enq_ready", 32'(enq_ready), 1);
    chk("rst_issue_valid", 32'(issue_valid), 0);
    chk("rst_issue_data", 32'(issue_data), 0);
    chk("rst_occupancy", 32'(occupancy), 0);
    @(posedge clk); #1;
    rst_n = 1;

    // A waits on rs1=3, B ready; B goes first, A only the cycle after its wakeup
    enq(pk(0, 3, 5), 0, 0, 0); #1;
    chk("a_enq_no_issue", 32'(issue_valid), 0);
    tick();
    enq(pk(0, 0, 6), 0, 0, 0); #1;
    chk("b_enq_a_not_ready", 32'(issue_valid), 0);
    chk("b_enq_occ", 32'(occupancy), 1);
    tick(); #1;
    chk("b_issue_valid", 32'(issue_valid), 1);
    chk("b_issue_data", 32'(issue_data), 32'(pk(0, 0, 6)));
    chk("b_issue_occ", 32'(occupancy), 2);
    tick();
    wk1_valid = 1; wk1_dest = 3; #1;
    chk("a_wake_same_cycle", 32'(issue_valid), 0);
    tick(); #1;
    chk("a_issue_valid", 32'(issue_valid), 1);
    chk("a_issue_data", 32'(issue_data), 32'(pk(0, 3, 5)));
    tick(); #1;
    chk("ab_drained", 32'(occupancy), 0);

    // Divide C blocks D until the cycle after div_done
    enq(pk(0, 0, 10), 1, 1, 1); #1;
    tick();
    enq(pk(0, 0, 11), 0, 1, 1); #1;
    chk("c_issue_valid", 32'(issue_valid), 1);
    chk("c_issue_data", 32'(issue_data), 32'(pk(0, 0, 10)));
    tick(); #1;
    chk("d_wait_occ", 32'(occupancy), 1);
    for (int i = 0; i < 12; i++) begin
      chk("d_held", 32'(issue_valid), 0);
      tick();
    end
    div_done = 1; #1;
    chk("d_div_done_cycle", 32'(issue_valid), 0);
    tick(); #1;
    chk("d_issue_valid", 32'(issue_valid), 1);
    chk("d_issue_data", 32'(issue_data), 32'(pk(0, 0, 11)));
    tick();

    // Fill to DEPTH with entries waiting on tags 20..27
    for (int i = 0; i < 8; i++) begin
      enq(pk(0, 20 + i, i), 0, 0, 0);
      tick();
    end
    #1;
    chk("full_enq_ready", 32'(enq_ready), 0);
    chk("full_occ", 32'(occupancy), 8);
    enq(pk(0, 0, 9), 0, 1, 1);
    tick(); #1;
    chk("full_drop_occ", 32'(occupancy), 8);
    chk("full_drop_no_issue", 32'(issue_valid), 0);
    wk0_valid = 1; wk0_dest = 22;
    tick(); #1;
    chk("full_wake_issue", 32'(issue_valid), 1);
    chk("full_wake_data", 32'(issue_data), 32'(pk(0, 22, 2)));
    chk("full_ready_same_cycle", 32'(enq_ready), 0);
    tick(); #1;
    chk("full_ready_next", 32'(enq_ready), 1);
    chk("full_occ_next", 32'(occupancy), 7);
    flush = 1; enq(pk(0, 0, 9), 0, 1, 1); #1;
    chk("flush_no_issue", 32'(issue_valid), 0);
    tick(); #1;
    chk("flush_occ", 32'(occupancy), 0);
    chk("flush_no_stale_issue", 32'(issue_valid), 0);

    // Issue from index 1 concurrent with enqueue at count=4; order preserved
    for (int i = 0; i < 4; i++) begin
      enq(pk(0, 30 + i, 16 + i), 0, 0, 0);
      tick();
    end
    wk1_valid = 1; wk1_dest = 31; #1;
    chk("mid_wake_no_issue", 32'(issue_valid), 0);
    tick();
    enq(pk(0, 34, 20), 0, 0, 0); #1;
    chk("mid_issue_valid", 32'(issue_valid), 1);
    chk("mid_issue_data", 32'(issue_data), 32'(pk(0, 31, 17)));
    tick(); #1;
    chk("mid_occ_kept", 32'(occupancy), 4);
    wk0_valid = 1; wk0_dest = 34; wk1_valid = 1; wk1_dest = 32;
    tick(); #1;
    chk("order_e2_first", 32'(issue_data), 32'(pk(0, 32, 18)));
    tick(); #1;
    chk("order_e4_data", 32'(issue_data), 32'(pk(0, 34, 20)));
    chk("order_e4_occ", 32'(occupancy), 3);
    tick();
    wk0_valid = 1; wk0_dest = 30; wk1_valid = 1; wk1_dest = 30;
    tick(); #1;
    chk("dup_wake_e0", 32'(issue_data), 32'(pk(0, 30, 16)));
    tick(); #1;
    chk("e3_not_ready", 32'(issue_valid), 0);
    wk0_valid = 1; wk0_dest = 33;
    tick(); #1;
    chk("e3_issue", 32'(issue_data), 32'(pk(0, 33, 19)));
    tick(); #1;
    chk("mid_drained", 32'(occupancy), 0);

    // Flush during WAIT_DIV with 5 queued entries
    enq(pk(0, 0, 32), 1, 1, 1);
    tick();
    enq(pk(0, 0, 33), 0, 1, 1); #1;
    chk("f_issue_data", 32'(issue_data), 32'(pk(0, 0, 32)));
    tick();
    for (int i = 0; i < 4; i++) begin
      enq(pk(0, 0, 34 + i), 0, 1, 1);
      tick();
    end
    #1;
    chk("wd_occ5", 32'(occupancy), 5);
    chk("wd_no_issue", 32'(issue_valid), 0);
    flush = 1; div_done = 1; enq(pk(0, 0, 40), 0, 1, 1); #1;
    chk("wd_flush_no_issue", 32'(issue_valid), 0);
    tick(); #1;
    chk("wd_flush_occ", 32'(occupancy), 0);
    enq(pk(0, 0, 38), 0, 1, 1); #1;
    chk("h_enq_no_issue", 32'(issue_valid), 0);
    tick();
    div_done = 1; #1;
    chk("h_issue_run", 32'(issue_valid), 1);
    chk("h_issue_data", 32'(issue_data), 32'(pk(0, 0, 38)));
    tick(); #1;
    chk("h_done_ignored_occ", 32'(occupancy), 0);

    // Same-cycle wakeup at enqueue on both ports; then ready flags supplied at dispatch
    enq(pk(8, 7, 39), 0, 0, 0);
    wk0_valid = 1; wk0_dest = 7; wk1_valid = 1; wk1_dest = 8;
    tick(); #1;
    chk("enq_wake_issue", 32'(issue_valid), 1);
    chk("enq_wake_data", 32'(issue_data), 32'(pk(8, 7, 39)));
    enq(pk(10, 9, 41), 0, 1, 1);
    tick(); #1;
    chk("rdy_in_issue", 32'(issue_data), 32'(pk(10, 9, 41)));
    tick();

    // Reset while in WAIT_DIV
    enq(pk(0, 0, 48), 1, 1, 1);
    tick();
    enq(pk(0, 0, 49), 0, 1, 1);
    tick(); #1;
    chk("rw_wait_no_issue", 32'(issue_valid), 0);
    rst_n = 0; #1;
    chk("rw_occ", 32'(occupancy), 0);
    chk("rw_enq_ready", 32'(enq_ready), 1);
    #2;
    rst_n = 1;
    tick();
    enq(pk(0, 0, 50), 0, 1, 1);
    tick(); #1;
    chk("rw_run_issue", 32'(issue_data), 32'(pk(0, 0, 50)));
    tick();

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
